pc_gen: RTL and testbench

PC_GEN -- requirements
Module: pc_gen

---
 rtl/pc_gen_pkg.sv | 15 +
 rtl/pc_gen_ras_stack.sv | 72 +++++++
 rtl/pc_gen.sv | 104 ++++++++++
 tb/tb_pc_gen.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/pc_gen_pkg.sv
// Shared CPU package: next-PC select encodings and the default reset /
// exception vectors, used by pc_gen and by the controller that drives npc_sel.
package pc_gen_pkg;

  typedef enum logic [1:0] {
    NPC_SEQ    = 2'd0,  // fall through to pc_f+4
    NPC_BRANCH = 2'd1,  // conditional branch, taken when br_taken=1
    NPC_JUMP   = 2'd2,  // j / jal, pseudo-direct target
    NPC_JR     = 2'd3   // jr / jalr, register target
  } npc_sel_e;

  localparam logic [31:0] RESET_PC_DEF = 32'h0000_3000;
  localparam logic [31:0] EXC_PC_DEF   = 32'h0000_4180;

endpackage

// File: rtl/pc_gen_ras_stack.sv
// ras_stack: return-address stack kept as a circular buffer.
// Ports:
//   clk, reset  - clock, synchronous active-high reset (pointer and count only)
//   push, pop   - already qualified by the caller (stall/exception gating)
//   addr        - return address to push / replace with
//   top         - newest entry, 0 when empty
//   valid       - stack non-empty
// A push when full overwrites the oldest slot and count saturates; a pop when
// empty is ignored; push+pop together replaces the top (or pushes if empty).
module ras_stack #(
  parameter int W         = 32,
  parameter int RAS_DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] addr,
  output logic [W-1:0] top,
  output logic         valid
);

  localparam int PW = $clog2(RAS_DEPTH);
  localparam int CW = PW + 1;

  logic [W-1:0]  mem [RAS_DEPTH];
  logic [PW-1:0] ptr;
  logic [CW-1:0] count;

  logic          empty;
  logic          full;
  logic          replace;
  logic          grow;
  logic          shrink;
  logic          wr_en;
  logic [PW-1:0] wr_idx;

  assign empty   = (count == '0);
  assign full    = (count == CW'(RAS_DEPTH));
  assign replace = push && pop && !empty;
  assign grow    = push && !replace;
  assign shrink  = pop && !push && !empty;

  // The pointer always names the newest entry; growing advances it first,
  // so a full buffer naturally lands on (and overwrites) the oldest slot.
  always_comb begin
    wr_en  = grow || replace;
    wr_idx = replace ? ptr : ptr + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr   <= '0;
      count <= '0;
    end else if (grow) begin
      ptr <= ptr + 1'b1;
      if (!full) count <= count + 1'b1;
    end else if (shrink) begin
      ptr   <= ptr - 1'b1;
      count <= count - 1'b1;
    end
  end

  // Entry storage carries no reset; stale contents are masked by count.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_idx] <= addr;
  end

  assign valid = !empty;
  assign top   = empty ? '0 : mem[ptr];

endmodule

// File: rtl/pc_gen.sv
// pc_gen: fetch program-counter register, next-PC target mux and RAS.
// Ports:
//   clk, reset        - clock, synchronous active-high reset
//   stall             - hold PC and RAS (exceptions/eret still taken)
//   pc4_d, ir_d       - PC+4 and instruction word of the instruction in D
//   npc_sel, br_taken - redirect select and resolved branch condition
//   jr_target         - register operand for jr/jalr
//   is_call, is_ret   - D holds jal/jalr, D holds jr $ra
//   exc_req, eret,epc - exception entry, exception return and its address
//   pc_f, pc4_f       - registered fetch PC and its +4
//   ras_top/ras_valid - RAS prediction
//   ras_miss          - one-cycle pulse: jr $ra target disagreed with the RAS
module pc_gen
  import pc_gen_pkg::*;
#(
  parameter int         W         = 32,
  parameter logic [W-1:0] RESET_PC = W'(RESET_PC_DEF),
  parameter logic [W-1:0] EXC_PC   = W'(EXC_PC_DEF),
  parameter int         RAS_DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         stall,
  input  logic [W-1:0] pc4_d,
  input  logic [31:0]  ir_d,
  input  logic [1:0]   npc_sel,
  input  logic         br_taken,
  input  logic [W-1:0] jr_target,
  input  logic         is_call,
  input  logic         is_ret,
  input  logic         exc_req,
  input  logic         eret,
  input  logic [W-1:0] epc,
  output logic [W-1:0] pc_f,
  output logic [W-1:0] pc4_f,
  output logic [W-1:0] ras_top,
  output logic         ras_valid,
  output logic         ras_miss
);

  logic signed [W-1:0] br_off;
  logic [W-1:0]        br_target;
  logic [W-1:0]        pc_d;
  logic [W-1:0]        jump_target;
  logic [W-1:0]        next_pc;
  logic                advance;
  logic                ras_push;
  logic                ras_pop;
  logic                is_jr;
  logic                unused_bits;

  assign pc4_f = pc_f + W'(4);

  assign br_off      = {{(W-18){ir_d[15]}}, ir_d[15:0], 2'b00};
  assign br_target   = pc4_d + $unsigned(br_off);
  assign pc_d        = pc4_d - W'(4);
  assign jump_target = W'({pc_d[W-1:W-4], ir_d[25:0], 2'b00});
  assign unused_bits = &{1'b0, ir_d[31:26], pc_d[W-5:0]};

  // Normal D-stage progress: anything that overrides it (stall, exception
  // entry, eret) also freezes the RAS.
  assign advance  = !stall && !exc_req && !eret;
  assign ras_push = advance && is_call;
  assign ras_pop  = advance && is_ret;
  assign is_jr    = (npc_sel == NPC_JR);

  always_comb begin
    next_pc = pc4_f;
    case (npc_sel_e'(npc_sel))
      NPC_BRANCH: if (br_taken) next_pc = br_target;
      NPC_JUMP:   next_pc = jump_target;
      NPC_JR:     next_pc = jr_target;
      default:    next_pc = pc4_f;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset)        pc_f <= RESET_PC;
    else if (exc_req) pc_f <= EXC_PC;
    else if (eret)    pc_f <= epc;
    else if (!stall)  pc_f <= next_pc;
  end

  // Judged against the prediction visible before this cycle's pop.
  always_ff @(posedge clk) begin
    if (reset) ras_miss <= 1'b0;
    else       ras_miss <= ras_pop && is_jr && (!ras_valid || (ras_top != jr_target));
  end

  // Return address skips the delay slot: pc4_d is the slot, +4 the return.
  ras_stack #(
    .W         (W),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk   (clk),
    .reset (reset),
    .push  (ras_push),
    .pop   (ras_pop),
    .addr  (pc4_d + W'(4)),
    .top   (ras_top),
    .valid (ras_valid)
  );

endmodule

// File: tb/tb_pc_gen.sv
module tb_pc_gen;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset, stall, br_taken, is_call, is_ret, exc_req, eret;
  logic [31:0] pc4_d, ir_d, jr_target, epc;
  logic [1:0]  npc_sel;
  logic [31:0] pc_f, pc4_f, ras_top;
  logic        ras_valid, ras_miss;

  always #5 clk = ~clk;

  pc_gen #(.W(32), .RAS_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .stall(stall), .pc4_d(pc4_d), .ir_d(ir_d),
    .npc_sel(npc_sel), .br_taken(br_taken), .jr_target(jr_target),
    .is_call(is_call), .is_ret(is_ret), .exc_req(exc_req), .eret(eret),
    .epc(epc), .pc_f(pc_f), .pc4_f(pc4_f), .ras_top(ras_top),
    .ras_valid(ras_valid), .ras_miss(ras_miss)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] pc4;
    logic [31:0] top;
    logic        valid;
    logic        miss;
    string       tag;
  } exp_t;

  exp_t        sb[$];
  int          n_cmp = 0;
  int          n_bad = 0;

  // Reference model state: the RAS is an unbounded-then-trimmed queue, newest at the back.
  logic [31:0] m_pc;
  logic [31:0] m_ras[$];
  logic        m_miss;
  string       cur_tag;

  task automatic chk(input string name, input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s [%s] at %0t: got 0x%08h expected 0x%08h", name, tag, $time, act, exp);
    end
  endtask

  // Monitor: the DUT presents its state every cycle; compare shortly after each edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("pc_f",      e.tag, pc_f,              e.pc);
        chk("pc4_f",     e.tag, pc4_f,             e.pc4);
        chk("ras_top",   e.tag, ras_top,           e.top);
        chk("ras_valid", e.tag, {31'b0, ras_valid}, {31'b0, e.valid});
        chk("ras_miss",  e.tag, {31'b0, ras_miss},  {31'b0, e.miss});
      end
    end
  end

  task automatic idle();
    reset = 0; stall = 0; br_taken = 0; is_call = 0; is_ret = 0;
    exc_req = 0; eret = 0; npc_sel = 2'd0;
    pc4_d = 32'h0; ir_d = 32'h0; jr_target = 32'h0; epc = 32'h0;
  endtask

  // Advance the model by one edge using the inputs now on the pins, queue the
  // expected post-edge outputs, then wait until the next input slot.
  task automatic cyc(input string tag);
    exp_t        e;
    logic [31:0] ret_addr;
    logic [31:0] tgt;
    ret_addr = pc4_d + 32'd4;
    if (reset) begin
      m_pc = 32'h0000_3000; m_ras.delete(); m_miss = 0;
    end else if (exc_req) begin
      m_pc = 32'h0000_4180; m_miss = 0;
    end else if (eret) begin
      m_pc = epc; m_miss = 0;
    end else if (stall) begin
      m_miss = 0;
    end else begin
      m_miss = is_ret && (npc_sel == 2'd3) &&
               ((m_ras.size() == 0) || (m_ras[$] != jr_target));
      case (npc_sel)
        2'd1:    tgt = br_taken ? pc4_d + 32'($signed(ir_d[15:0]) * 4) : m_pc + 32'd4;
        2'd2:    tgt = ((pc4_d - 32'd4) & 32'hF000_0000) | ({6'b0, ir_d[25:0]} << 2);
        2'd3:    tgt = jr_target;
        default: tgt = m_pc + 32'd4;
      endcase
      m_pc = tgt;
      if (is_call && is_ret) begin
        if (m_ras.size() == 0) m_ras.push_back(ret_addr);
        else m_ras[$] = ret_addr;
      end else if (is_call) begin
        m_ras.push_back(ret_addr);
        if (m_ras.size() > DEPTH) void'(m_ras.pop_front());
      end else if (is_ret) begin
        if (m_ras.size() > 0) void'(m_ras.pop_back());
      end
    end
    e.pc    = m_pc;
    e.pc4   = m_pc + 32'd4;
    e.valid = (m_ras.size() > 0);
    e.top   = e.valid ? m_ras[$] : 32'h0;
    e.miss  = m_miss;
    e.tag   = tag;
    sb.push_back(e);
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] lost;
    idle();
    reset = 1;
    m_pc = 32'h0; m_miss = 0;
    @(negedge clk);

    // Reset, then free-running fetch.
    reset = 1; cyc("reset");
    idle();
    for (int i = 0; i < 3; i++) cyc("free");

    // Backward branch taken, then not taken.
    idle(); pc4_d = 32'h3008; ir_d = 32'h0000_FFFE; npc_sel = 2'd1; br_taken = 1; cyc("br_taken");
    br_taken = 0; cyc("br_not_taken");
    npc_sel = 2'd0; br_taken = 1; cyc("seq_ignores_br");

    // jal pushes the delay-slot return address.
    idle(); pc4_d = 32'h3010; ir_d = 32'h0000_0C40; npc_sel = 2'd2; is_call = 1; cyc("jal");

    // Five calls overflow a 4-deep stack, then five returns.
    idle(); reset = 1; cyc("reset2");
    idle();
    for (int i = 0; i < 5; i++) begin
      pc4_d = 32'h0000_5000 + 32'(i * 16); ir_d = 32'h0000_1000 + 32'(i);
      npc_sel = 2'd2; is_call = 1; cyc("call5");
    end
    lost = 32'h0000_5004;
    idle();
    for (int i = 0; i < 5; i++) begin
      npc_sel = 2'd3; is_ret = 1;
      jr_target = (i < 4) ? 32'h0000_5044 - 32'(i * 16) : lost;
      cyc("ret5");
    end
    idle(); cyc("after_miss");

    // Exception beats stall and redirect; eret while stalled.
    idle(); pc4_d = 32'h3010; npc_sel = 2'd2; is_call = 1; cyc("call_pre_exc");
    stall = 1; ir_d = 32'h0000_0123; exc_req = 1; cyc("exc_stall");
    idle(); stall = 1; npc_sel = 2'd2; is_call = 1; cyc("stall_hold");
    idle(); stall = 1; eret = 1; epc = 32'h3020; is_ret = 1; cyc("eret");
    idle(); npc_sel = 2'd3; is_ret = 1; jr_target = 32'h3014; cyc("ret_hit");

    // Reset dominates a simultaneous call and exception.
    idle(); reset = 1; is_call = 1; exc_req = 1; npc_sel = 2'd2; pc4_d = 32'h7000; cyc("reset_dom");

    // Randomised traffic.
    for (int i = 0; i < 2000; i++) begin
      idle();
      reset    = ($urandom_range(0, 59) == 0);
      stall    = ($urandom_range(0, 3) == 0);
      exc_req  = ($urandom_range(0, 19) == 0);
      eret     = ($urandom_range(0, 19) == 0);
      npc_sel  = 2'($urandom_range(0, 3));
      br_taken = 1'($urandom);
      is_call  = ($urandom_range(0, 2) == 0);
      is_ret   = ($urandom_range(0, 2) == 0);
      pc4_d    = $urandom;
      ir_d     = $urandom;
      epc      = $urandom;
      jr_target = ($urandom_range(0, 1) == 0 && m_ras.size() > 0) ? m_ras[$] : $urandom;
      cyc("random");
    end

    idle();
    cyc("drain");
    @(posedge clk);
    #2;
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
